// File: rtl/carga_operandos.sv
// Operand sequencer for the adder stage: debounces the load/clear buttons and
// steps through A-load, B-load, one-cycle adder enable, then result display.
module carga_operandos #(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] dato_in,
  input  logic             btn_cargar,
  input  logic             btn_borrar,
  output logic [WIDTH-1:0] reg0,
  output logic [WIDTH-1:0] reg1,
  output logic             enable_suma,
  output logic [1:0]       estado,
  output logic             listo
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES);
  localparam int unsigned NUM_BTN = 2;

  localparam logic [1:0] ESPERA_A = 2'd0;
  localparam logic [1:0] ESPERA_B = 2'd1;
  localparam logic [1:0] EJECUTA  = 2'd2;
  localparam logic [1:0] MUESTRA  = 2'd3;

  logic [NUM_BTN-1:0] raw;
  logic [NUM_BTN-1:0] sync1;
  logic [NUM_BTN-1:0] sync2;
  logic [NUM_BTN-1:0] deb;
  logic [NUM_BTN-1:0] deb_q;
  logic [NUM_BTN-1:0] pulse;
  logic [CNT_W-1:0]   cnt [NUM_BTN];

  logic             ld;
  logic             clr;
  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [WIDTH-1:0] reg0_next;
  logic [WIDTH-1:0] reg1_next;

  assign raw = {btn_borrar, btn_cargar};

  // Per button: 2-FF sync, stability counter, registered rising edge of the debounced level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_q <= '0;
      pulse <= '0;
      for (int i = 0; i < NUM_BTN; i++) cnt[i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_q <= deb;
      pulse <= deb & ~deb_q;
      for (int i = 0; i < NUM_BTN; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_MAX) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  assign ld  = pulse[0];
  assign clr = pulse[1];

  // Next state and operand values; clear outranks load in every state
  always_comb begin
    state_next = state;
    reg0_next  = reg0;
    reg1_next  = reg1;
    if (clr) begin
      state_next = ESPERA_A;
      reg0_next  = '0;
      reg1_next  = '0;
    end else begin
      case (state)
        ESPERA_A: if (ld) begin
          reg0_next  = dato_in;
          state_next = ESPERA_B;
        end
        ESPERA_B: if (ld) begin
          reg1_next  = dato_in;
          state_next = EJECUTA;
        end
        EJECUTA:  state_next = MUESTRA;
        MUESTRA:  if (ld) begin
          reg0_next  = dato_in;
          state_next = ESPERA_B;
        end
        default:  state_next = ESPERA_A;
      endcase
    end
  end

  // Outputs registered from the next state so they line up with estado
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ESPERA_A;
      reg0        <= '0;
      reg1        <= '0;
      enable_suma <= 1'b0;
      listo       <= 1'b0;
    end else begin
      state       <= state_next;
      reg0        <= reg0_next;
      reg1        <= reg1_next;
      enable_suma <= (state_next == EJECUTA);
      listo       <= (state_next == MUESTRA);
    end
  end

  assign estado = state;

endmodule

// File: tb/tb_carga_operandos.sv
// Directed bench for carga_operandos with DEBOUNCE_CYCLES=4.
module tb_carga_operandos;

  logic       clk;
  logic       rst_n;
  logic [3:0] dato_in;
  logic       btn_cargar;
  logic       btn_borrar;
  logic [3:0] reg0;
  logic [3:0] reg1;
  logic       enable_suma;
  logic [1:0] estado;
  logic       listo;

  int checks;
  int errors;
  int en_count;
  int en_consec;
  logic en_prev;

  carga_operandos #(.WIDTH(4), .DEBOUNCE_CYCLES(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .dato_in    (dato_in),
    .btn_cargar (btn_cargar),
    .btn_borrar (btn_borrar),
    .reg0       (reg0),
    .reg1       (reg1),
    .enable_suma(enable_suma),
    .estado     (estado),
    .listo      (listo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count adder enables and any back-to-back assertion
  initial begin
    en_count  = 0;
    en_consec = 0;
    en_prev   = 1'b0;
  end
  always @(posedge clk) begin
    #1;
    if (enable_suma) en_count++;
    if (enable_suma && en_prev) en_consec++;
    en_prev = enable_suma;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic press(input logic ld, input logic cl, input logic [3:0] d, input int hold);
    dato_in    = d;
    btn_cargar = ld;
    btn_borrar = cl;
    repeat (hold) @(negedge clk);
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;
    repeat (12) @(negedge clk);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst_n      = 1'b1;
    dato_in    = '0;
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;

    // Asynchronous reset, no clock edge needed
    #2 rst_n = 1'b0;
    #1;
    check("rst_reg0", 32'(reg0), 32'h0);
    check("rst_reg1", 32'(reg1), 32'h0);
    check("rst_en", 32'(enable_suma), 32'h0);
    check("rst_estado", 32'(estado), 32'h0);
    check("rst_listo", 32'(listo), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    check("idle_estado", 32'(estado), 32'h0);
    check("idle_reg0", 32'(reg0), 32'h0);
    check("idle_listo", 32'(listo), 32'h0);

    // Latency: raw rises before edge 0, load lands at edge 8
    dato_in    = 4'h3;
    btn_cargar = 1'b1;
    repeat (8) @(negedge clk);
    check("lat_reg0_e7", 32'(reg0), 32'h0);
    check("lat_estado_e7", 32'(estado), 32'h0);
    @(negedge clk);
    check("lat_reg0_e8", 32'(reg0), 32'h3);
    check("lat_estado_e8", 32'(estado), 32'h1);
    @(negedge clk);
    btn_cargar = 1'b0;
    repeat (12) @(negedge clk);

    // Operand B, then one enable and display
    press(1'b1, 1'b0, 4'h5, 10);
    check("full_reg0", 32'(reg0), 32'h3);
    check("full_reg1", 32'(reg1), 32'h5);
    check("full_estado", 32'(estado), 32'h3);
    check("full_listo", 32'(listo), 32'h1);
    check("full_en_count", 32'(en_count), 32'd1);

    // Reload from display
    press(1'b1, 1'b0, 4'hF, 10);
    check("reload_reg0", 32'(reg0), 32'hF);
    check("reload_reg1", 32'(reg1), 32'h5);
    check("reload_estado", 32'(estado), 32'h1);
    check("reload_listo", 32'(listo), 32'h0);
    press(1'b1, 1'b0, 4'h1, 10);
    check("reload_b_reg1", 32'(reg1), 32'h1);
    check("reload_b_estado", 32'(estado), 32'h3);
    check("reload_b_en_count", 32'(en_count), 32'd2);

    // Clear from display
    press(1'b0, 1'b1, 4'h1, 10);
    check("clr_m_estado", 32'(estado), 32'h0);
    check("clr_m_reg0", 32'(reg0), 32'h0);
    check("clr_m_reg1", 32'(reg1), 32'h0);
    check("clr_m_listo", 32'(listo), 32'h0);

    // Bouncing contact then a steady hold: exactly one load
    dato_in = 4'h7;
    for (int k = 0; k < 2; k++) begin
      btn_cargar = 1'b1;
      repeat (2) @(negedge clk);
      btn_cargar = 1'b0;
      repeat (2) @(negedge clk);
    end
    press(1'b1, 1'b0, 4'h7, 10);
    check("bounce_reg0", 32'(reg0), 32'h7);
    check("bounce_estado", 32'(estado), 32'h1);

    // Simultaneous load and clear in ESPERA_B: clear wins
    press(1'b1, 1'b1, 4'hA, 10);
    check("prio_reg0", 32'(reg0), 32'h0);
    check("prio_reg1", 32'(reg1), 32'h0);
    check("prio_estado", 32'(estado), 32'h0);
    check("prio_en_count", 32'(en_count), 32'd2);

    // Short glitch is filtered
    press(1'b1, 1'b0, 4'h9, 3);
    check("glitch_estado", 32'(estado), 32'h0);
    check("glitch_reg0", 32'(reg0), 32'h0);

    // Clear arriving while in EJECUTA: enable kept, then back to ESPERA_A
    press(1'b1, 1'b0, 4'h2, 10);
    check("ej_a_reg0", 32'(reg0), 32'h2);
    dato_in    = 4'h6;
    btn_cargar = 1'b1;
    @(negedge clk);
    btn_borrar = 1'b1;
    repeat (8) @(negedge clk);
    check("ej_estado", 32'(estado), 32'h2);
    check("ej_en", 32'(enable_suma), 32'h1);
    check("ej_reg1", 32'(reg1), 32'h6);
    @(negedge clk);
    check("ej_clr_estado", 32'(estado), 32'h0);
    check("ej_clr_en", 32'(enable_suma), 32'h0);
    check("ej_clr_reg1", 32'(reg1), 32'h0);
    check("ej_en_count", 32'(en_count), 32'd3);
    btn_cargar = 1'b0;
    btn_borrar = 1'b0;
    repeat (12) @(negedge clk);

    // Reset mid-operation, between clock edges
    press(1'b1, 1'b0, 4'h4, 10);
    check("mid_pre_reg0", 32'(reg0), 32'h4);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_reg0", 32'(reg0), 32'h0);
    check("mid_rst_estado", 32'(estado), 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (10) @(negedge clk);
    check("mid_post_estado", 32'(estado), 32'h0);
    check("mid_en_count", 32'(en_count), 32'd3);
    check("en_back_to_back", 32'(en_consec), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/carga_operandos.md
Name: carga_operandos

Overview:
Upstream operand sequencer for the 4-bit adder stage. It takes the board switches (dato_in) and two push buttons (cargar, borrar). Each button is synchronised and debounced, then turned into a single-cycle press event. A 4-state FSM captures operand A, then operand B, then issues exactly one enable_suma pulse to the adder. The adder consumes reg0, reg1 and enable_suma on the same clk.

Parameters:
WIDTH, 4, operand width; drives the dato_in, reg0 and reg1 widths.
DEBOUNCE_CYCLES, 4, consecutive stable synchronised cycles needed before the debounced level changes; minimum 1; 4 is for simulation, a board build uses about 500000.

Ports:
clk  input  1  system clock; all state updates on its rising edge
rst_n  input  1  asynchronous active-low reset
dato_in  input  WIDTH  switch value; quasi-static, not synchronised, sampled only on the load edge
btn_cargar  input  1  raw load button, active-high, asynchronous to clk
btn_borrar  input  1  raw clear button, active-high, asynchronous to clk
reg0  output  WIDTH  operand A to the adder, registered
reg1  output  WIDTH  operand B to the adder, registered
enable_suma  output  1  one-cycle adder enable, registered
estado  output  2  current FSM state code
listo  output  1  high while in MUESTRA (adder result valid for display)

Behaviour:
Reset:
- rst_n low clears everything immediately, independent of clk: reg0=0, reg1=0, enable_suma=0, estado=ESPERA_A, listo=0.
- Synchronisers, debounced levels, debounce counters and press pulses also clear to 0.
- Reset mid-operation abandons any partial load; no enable_suma is emitted.

Button path (identical for each button):
- 2-FF synchroniser gives s2.
- Debounce counter increments on each cycle where s2 != deb, and clears when s2 == deb.
- When the count reaches DEBOUNCE_CYCLES, deb takes the value of s2 and the counter clears.
- The press pulse is a registered rising edge of deb: high for exactly 1 cycle per press.
- Timing: raw input rising before edge 0 and held → deb high after edge DEBOUNCE_CYCLES+2 → pulse high after edge DEBOUNCE_CYCLES+3 → FSM acts at edge DEBOUNCE_CYCLES+4.
- Glitches shorter than DEBOUNCE_CYCLES synchronised cycles produce no pulse.
- Holding the button produces exactly one pulse; release also needs DEBOUNCE_CYCLES stable cycles.

FSM (codes ESPERA_A=0, ESPERA_B=1, EJECUTA=2, MUESTRA=3):
- ESPERA_A: on the cargar pulse, reg0 ← dato_in and go to ESPERA_B.
- ESPERA_B: on the cargar pulse, reg1 ← dato_in and go to EJECUTA.
- EJECUTA: unconditional single-cycle state. enable_suma=1 during the cycle the FSM is in EJECUTA (registered, asserted from entry into EJECUTA). Next state is MUESTRA. enable_suma is 0 in every other state.
- MUESTRA: listo=1; reg0 and reg1 hold. On the cargar pulse, reg0 ← dato_in, reg1 holds its old value until reloaded, and go to ESPERA_B.
- borrar pulse in any state: reg0=0, reg1=0, go to ESPERA_A.
  - borrar wins over a simultaneous cargar pulse.
  - If borrar arrives while in EJECUTA, the enable_suma pulse for that cycle has already been issued and is not retracted; the FSM then goes to ESPERA_A instead of MUESTRA.
- The cargar pulse is ignored in EJECUTA; the pulse is lost, not queued.
- reg0 and reg1 change only on the load/clear transitions above. enable_suma never asserts on two consecutive cycles.

Arithmetic and width:
- No arithmetic is done in this block.
- dato_in is copied bit-for-bit into reg0/reg1.
- estado is 2 bits; unreachable codes do not exist.

Test Plan:
(DEBOUNCE_CYCLES=4 for all scenarios.)
- Reset → rst_n=0 mid-cycle → all outputs 0 and estado=0 with no clk edge needed. Release rst_n, idle 20 cycles → outputs unchanged.
- Full operation → dato_in=4'h3, cargar held 10 cycles; dato_in=4'h5, cargar held 10 cycles → reg0=3, reg1=5, enable_suma high exactly 1 cycle, then estado=3 and listo=1.
- Latency → cargar raw rises before edge 0 → reg0 updates at edge 8 (DEBOUNCE_CYCLES+4), not before.
- Bounce → cargar toggles 1,0,1,0 with 2-cycle pulses, then held high 10 cycles → exactly one load. Glitch of 3 cycles alone → no load, estado stays 0.
- Clear priority → in ESPERA_B, cargar and borrar debounced pulses coincide → reg0=0, reg1=0, estado=0, no enable_suma. Borrar in MUESTRA → estado=0.
- Reload from MUESTRA → after 3+5, dato_in=4'hF and cargar → reg0=F, reg1 still 5, estado=1. Then dato_in=4'h1 and cargar → reg1=1, one enable_suma pulse.
